instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer side of the PC: owns the architectural fetch PC and reads instruction memory at it.
//  Issues one request at a time (valid/ready request channel, valid-only response channel).
//  Presents each fetched word with its PC to decode over a valid/ready handshake.
//  Handles control-flow redirects, including discarding a response already in flight.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_WORD  32'h0000_0000  inst_data value at reset and after a flush (MIPS sll $0,$0,0)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  redirect_valid  in   1   branch/jump taken; load redirect_pc this cycle
//  redirect_pc     in   32  target PC; bits [1:0] ignored and forced to 00
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts the request this cycle
//  imem_req_addr   out  32  word-aligned fetch address (= current PC)
//  imem_rsp_valid  in   1   response data valid; exactly one per accepted request, >=1 cycle later
//  imem_rsp_data   in   32  instruction word
//  inst_valid      out  1   inst_pc/inst_data valid towards decode
//  inst_ready      in   1   decode consumes the instruction
//  inst_pc         out  32  PC of the presented instruction
//  inst_data       out  32  presented instruction word
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=REQ, inst_valid=0, inst_pc=0, inst_data=NOP_WORD.
//  imem_req_valid=1 only in REQ; imem_req_addr=pc. inst_valid=1 only in HOLD. Both are decoded from registered state.
//  States:
//   REQ:   redirect & req_ready -> pc=redirect_pc, DRAIN (the accepted request goes stale)
//          redirect & !req_ready -> pc=redirect_pc, stay REQ (an unaccepted request may be retargeted)
//          req_ready -> WAIT; otherwise hold with req_addr stable
//   WAIT:  redirect & rsp_valid -> drop data, pc=redirect_pc, REQ
//          redirect -> pc=redirect_pc, DRAIN
//          rsp_valid -> inst_pc=pc, inst_data=rsp_data, pc=pc+4, HOLD
//   HOLD:  redirect -> pc=redirect_pc, inst_data=NOP_WORD, REQ (held instruction flushed, never handshaken)
//          inst_ready -> REQ; otherwise hold with outputs stable
//   DRAIN: rsp_valid -> REQ (response discarded); a redirect here only updates pc and stays in DRAIN
//  Priority: redirect over every handshake in the same cycle. Single outstanding request, never two.
//  Throughput: 3 cycles per instruction minimum (REQ, WAIT, HOLD) with zero-wait imem and ready decode.
//  pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No carry or exception is raised.
//  An rsp_valid in REQ or HOLD is a protocol violation; it is ignored (assert in simulation).
//  Reset asserted mid-transaction: state returns to REQ at once and the in-flight response is forgotten.
//  Imem must be reset together with this block.
// STRUCTURE
//  Shared package mips_pkg: state encodings (S_REQ, S_WAIT, S_HOLD, S_DRAIN), PC_STEP=4, NOP_WORD.
//  Sub-module fetch_pc_reg: 32-bit register with async active-low reset to RESET_PC.
//   Load mux selects redirect_pc or pc+4 under a load enable.
//  This top level holds the FSM and the instruction output registers.
// TESTING
//  1 Reset, req_ready=1, rsp one cycle after accept, inst_ready=1 -> inst_pc 0,4,8 on every 3rd cycle; data matches imem.
//  2 inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst_pc, inst_data stable; no new imem request.
//  3 redirect to 32'h0000_0040 in WAIT, rsp 2 cycles later -> that rsp dropped; next req_addr=0x40; no inst_valid for the old word.
//  4 redirect in the same cycle as rsp_valid in WAIT, and separately in HOLD -> no stale instruction; next inst_pc=target.
//  5 redirect_pc=32'hFFFF_FFFE -> req_addr 32'hFFFF_FFFC; next fetch address 32'h0000_0000.
//  6 rst_n low while in WAIT -> outputs at reset values immediately; after release, first req_addr=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch state encodings and fetch constants
package mips_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - architectural fetch PC with redirect / sequential load mux
module fetch_pc_reg import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        sel_redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Redirect targets are forced word-aligned; sequential step wraps modulo 2^32.
  always_comb begin
    pc_next = sel_redirect ? (redirect_pc & ~32'd3) : (pc + PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch FSM with redirect handling
module instr_fetch_unit
  import mips_pkg::fetch_state_e, mips_pkg::S_REQ, mips_pkg::S_WAIT,
         mips_pkg::S_HOLD, mips_pkg::S_DRAIN;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc;
  logic         pc_load;
  logic         pc_sel_redirect;
  logic         inst_capture;
  logic         inst_flush;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (pc_load),
    .sel_redirect (pc_sel_redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect beats every handshake; DRAIN still owes one response before a new request.
  always_comb begin
    state_d         = state_q;
    pc_load         = 1'b0;
    pc_sel_redirect = 1'b0;
    inst_capture    = 1'b0;
    inst_flush      = 1'b0;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
          state_d         = imem_req_ready ? S_DRAIN : S_REQ;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
          state_d         = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          pc_load      = 1'b1;
          inst_capture = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
          inst_flush      = 1'b1;
          state_d         = S_REQ;
        end else if (inst_ready) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_pc   <= 32'h0000_0000;
      inst_data <= NOP_WORD;
    end else if (inst_capture) begin
      inst_pc   <= pc;
      inst_data <= imem_rsp_data;
    end else if (inst_flush) begin
      inst_data <= NOP_WORD;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == S_HOLD);

  // Responses are only legal while a request is outstanding.
  a_rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a small imem model
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] exp_q[$];
  int          hs_cyc[$];

  // imem model state: memory word at address a is 32'h1000_0000 + a
  int          rsp_delay = 1;
  logic        pending   = 1'b0;
  logic [31:0] p_addr    = 32'h0;
  int          p_cnt     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = rst_n && imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pending        = 1'b0;
      imem_rsp_valid = 1'b0;
    end else begin
      if (imem_rsp_valid) imem_rsp_valid = 1'b0;
      if (acc) begin
        pending = 1'b1;
        p_addr  = a;
        p_cnt   = rsp_delay;
      end
      if (pending) begin
        p_cnt--;
        if (p_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'h1000_0000 + p_addr;
          pending        = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d instructions still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_valid"}, {31'b0, inst_valid}, 32'd1);
  endtask

  // Monitor: a handshake happens when valid & ready and no redirect overrides it.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      logic [63:0] e;
      n_tests++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h data %h, expected no instruction", inst_pc, inst_data);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst_data} !== e) begin
          n_fail++;
          $display("FAIL sb_inst: got pc %h data %h, expected pc %h data %h",
                   inst_pc, inst_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b1;
    tick();
    tick();
    chk("rst_req_valid",  {31'b0, imem_req_valid}, 32'd1);
    chk("rst_req_addr",   imem_req_addr, 32'h0000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_pc",    inst_pc, 32'h0000_0000);
    chk("rst_inst_data",  inst_data, 32'h0000_0000);

    // 1: back-to-back sequential fetch
    rst_n = 1'b1;
    hs_cyc.delete();
    push(32'h0000_0000, 32'h1000_0000);
    push(32'h0000_0004, 32'h1000_0004);
    push(32'h0000_0008, 32'h1000_0008);
    wait_drain("t1");
    imem_req_ready = 1'b0;
    chk("t1_hs_count", hs_cyc.size(), 32'd3);
    if (hs_cyc.size() >= 3) begin
      chk("t1_spacing_a", hs_cyc[1] - hs_cyc[0], 32'd3);
      chk("t1_spacing_b", hs_cyc[2] - hs_cyc[1], 32'd3);
    end

    // 2: decode stall holds the instruction and blocks new requests
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid("t2");
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("t2_hold_pc",    inst_pc, 32'h0000_000C);
      chk("t2_hold_data",  inst_data, 32'h1000_000C);
      chk("t2_no_req",     {31'b0, imem_req_valid}, 32'd0);
    end
    push(32'h0000_000C, 32'h1000_000C);
    inst_ready = 1'b1;
    wait_drain("t2");

    // 3: redirect in WAIT, response arrives later and must be dropped
    rsp_delay      = 2;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("t3_drain_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_req_addr",  imem_req_addr, 32'h0000_0040);
    rsp_delay      = 1;
    imem_req_ready = 1'b1;
    push(32'h0000_0040, 32'h1000_0040);
    wait_drain("t3");
    imem_req_ready = 1'b0;

    // 4a: redirect coincident with the response in WAIT
    tick();
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    chk("t4a_req_addr", imem_req_addr, 32'h0000_0080);
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid("t4a");
    imem_req_ready = 1'b0;
    chk("t4a_inst_pc",   inst_pc, 32'h0000_0080);
    chk("t4a_inst_data", inst_data, 32'h1000_0080);

    // 4b: redirect in HOLD with decode ready in the same cycle flushes the word
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00C0;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t4b_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4b_inst_data",  inst_data, 32'h0000_0000);
    chk("t4b_req_addr",   imem_req_addr, 32'h0000_00C0);
    push(32'h0000_00C0, 32'h1000_00C0);
    imem_req_ready = 1'b1;
    wait_drain("t4b");
    imem_req_ready = 1'b0;

    // 5: unaligned redirect near the top of memory, then wrap to zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    push(32'h0000_0000, 32'h1000_0000);
    imem_req_ready = 1'b1;
    wait_drain("t5");
    imem_req_ready = 1'b0;
    chk("t5_wrap_pc", imem_req_addr, 32'h0000_0004);

    // 6: reset while a request is outstanding
    rsp_delay      = 2;
    imem_req_ready = 1'b1;
    tick();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("t6_req_valid",  {31'b0, imem_req_valid}, 32'd1);
    chk("t6_req_addr",   imem_req_addr, 32'h0000_0000);
    chk("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_inst_pc",    inst_pc, 32'h0000_0000);
    chk("t6_inst_data",  inst_data, 32'h0000_0000);
    tick();
    tick();
    rst_n     = 1'b1;
    rsp_delay = 1;
    chk("t6_first_addr", imem_req_addr, 32'h0000_0000);
    push(32'h0000_0000, 32'h1000_0000);
    wait_drain("t6");
    imem_req_ready = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
